// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder/subtractor cell reused LSB first,
// with a registered carry/borrow between bits and a start/done handshake.
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_q, op_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic ai, bi, bit_s, bit_c, last_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            work_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            work_q   <= work_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ai       = a_sh_q[0];
        bi       = b_sh_q[0];
        bit_s    = ai ^ bi ^ carry_q;
        bit_c    = op_q ? ((~ai & bi) | (bi & carry_q) | (carry_q & ~ai))
                        : ((ai & bi) | (bi & carry_q) | (carry_q & ai));
        last_bit = (cnt_q == CW'(WIDTH - 1));

        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        work_d   = work_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        if (state_q == S_IDLE && start) begin
            a_sh_d  = a;
            b_sh_d  = b;
            op_d    = op;
            carry_d = 1'b0;
            cnt_d   = '0;
        end else if (state_q == S_RUN) begin
            a_sh_d  = a_sh_q >> 1;
            b_sh_d  = b_sh_q >> 1;
            carry_d = bit_c;
            work_d  = {bit_s, work_q[WIDTH-1:1]};
            if (last_bit) begin
                // On the last bit ai/bi are the operand MSBs and bit_s is the result MSB.
                result_d = {bit_s, work_q[WIDTH-1:1]};
                cout_d   = bit_c;
                ovf_d    = op_q ? ((ai != bi) && (bit_s != ai))
                                : ((ai == bi) && (bit_s != ai));
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        result = result_q;
        cout   = cout_q;
        ovf    = ovf_q;
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub at WIDTH=8 (directed + random) and WIDTH=4 (full sweep).
module tb_serial_add_sub;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0, op8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] res8;
    logic       start4 = 1'b0, op4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] res4;

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
    );

    serial_add_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(res4), .cout(cout4), .ovf(ovf4)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int res;
        bit cout;
        bit ovf;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   wd[2] = '{8, 4};
    int   acc[2] = '{-100, -100};
    int   hold_res[2] = '{0, 0};
    bit   hold_cout[2] = '{1'b0, 1'b0};
    bit   hold_ovf[2] = '{1'b0, 1'b0};

    task automatic chk(input string name, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s cyc=%0d: got=%0h expected=%0h", name, cyc, got, expv);
        end
    endtask

    // Reference: plain integer arithmetic and signed range check.
    function automatic exp_t model(input int w, input bit op, input int a, input int b, input int due);
        exp_t e;
        int m = 1 << w;
        int full = op ? (a - b) : (a + b);
        int sa = (a >= m / 2) ? a - m : a;
        int sbv = (b >= m / 2) ? b - m : b;
        int sr = op ? (sa - sbv) : (sa + sbv);
        e.due  = due;
        e.res  = ((full % m) + m) % m;
        e.cout = op ? (a < b) : (full >= m);
        e.ovf  = (sr < -(m / 2)) || (sr > (m / 2) - 1);
        return e;
    endfunction

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int d = 0; d < 2; d++) begin
                bit   bsy, dn, co, ov, eb;
                int   r;
                exp_t e;
                bsy = (d == 0) ? busy8 : busy4;
                dn  = (d == 0) ? done8 : done4;
                r   = (d == 0) ? int'(res8) : int'(res4);
                co  = (d == 0) ? cout8 : cout4;
                ov  = (d == 0) ? ovf8 : ovf4;
                eb  = (cyc >= acc[d]) && (cyc <= acc[d] + wd[d]);
                chk($sformatf("busy%0d", wd[d]), int'(bsy), int'(eb));
                if (dn) begin
                    if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
                        chk($sformatf("done_unexpected%0d", wd[d]), 1, 0);
                    end else begin
                        e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
                        chk($sformatf("done_cycle%0d", wd[d]), cyc, e.due);
                        chk($sformatf("result%0d", wd[d]), r, e.res);
                        chk($sformatf("cout%0d", wd[d]), int'(co), int'(e.cout));
                        chk($sformatf("ovf%0d", wd[d]), int'(ov), int'(e.ovf));
                        hold_res[d]  = e.res;
                        hold_cout[d] = e.cout;
                        hold_ovf[d]  = e.ovf;
                    end
                end else begin
                    if (d == 0 && sb0.size() > 0 && cyc > sb0[0].due) begin
                        chk("done_missing8", 0, 1);
                        void'(sb0.pop_front());
                    end
                    if (d == 1 && sb1.size() > 0 && cyc > sb1[0].due) begin
                        chk("done_missing4", 0, 1);
                        void'(sb1.pop_front());
                    end
                end
                if (!eb) begin
                    chk($sformatf("hold_result%0d", wd[d]), r, hold_res[d]);
                    chk($sformatf("hold_cout%0d", wd[d]), int'(co), int'(hold_cout[d]));
                    chk($sformatf("hold_ovf%0d", wd[d]), int'(ov), int'(hold_ovf[d]));
                end
            end
        end
    end

    task automatic drive(input int d, input bit s, input bit op, input int a, input int b);
        if (d == 0) begin
            start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start4 = s; op4 = op; a4 = a[3:0]; b4 = b[3:0];
        end
    endtask

    // Called on a falling edge; returns on a falling edge.
    task automatic issue(input int d, input bit op, input int a, input int b, input bit spur);
        exp_t e;
        while (cyc < acc[d] + wd[d] + 1) @(negedge clk);
        drive(d, 1'b1, op, a, b);
        e = model(wd[d], op, a, b, cyc + 1 + wd[d]);
        if (d == 0) sb0.push_back(e); else sb1.push_back(e);
        acc[d] = cyc + 1;
        @(negedge clk);
        drive(d, 1'b0, 1'(op ^ 1'b1), int'($urandom), int'($urandom));
        if (spur) begin
            while (cyc < acc[d] + wd[d] + 1) begin
                drive(d, (cyc == acc[d] + wd[d]) ? 1'b1 : 1'($urandom_range(0, 1)),
                      1'($urandom), int'($urandom), int'($urandom));
                @(negedge clk);
            end
            drive(d, 1'b0, 1'b0, 0, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(0, 1'b0, 8'h5A, 8'h3C, 1'b1);
        issue(0, 1'b0, 8'hFF, 8'h01, 1'b0);
        issue(0, 1'b1, 8'h10, 8'h20, 1'b1);
        issue(0, 1'b1, 8'h80, 8'h01, 1'b0);
        for (int i = 0; i < 24; i++)
            issue(0, 1'($urandom), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  1'($urandom));

        // Reset landing on the edge that would process bit 3.
        issue(0, 1'b0, 8'h37, 8'h11, 1'b0);
        while (cyc < acc[0] + 3) @(negedge clk);
        rst = 1'b1;
        sb0.delete();
        sb1.delete();
        acc[0] = -100;
        acc[1] = -100;
        for (int d = 0; d < 2; d++) begin
            hold_res[d] = 0; hold_cout[d] = 1'b0; hold_ovf[d] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        chk("rst_result", int'(res8), 0);
        chk("rst_flags", int'({busy8, done8, cout8, ovf8}), 0);
        issue(0, 1'b0, 8'h01, 8'h01, 1'b0);

        for (int op = 0; op < 2; op++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    issue(1, 1'(op), a, b, 1'b0);

        repeat (12) @(negedge clk);
        chk("scoreboard_empty", sb0.size() + sb1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
